// File: rtl/dcache_axi_bridge_if.sv
// dcache_axi_bridge_if: data-cache refill/writeback port bundled with the
// five AXI4 channels that the bridge drives towards the SoC crossbar.
// Ports (signals):
//   cache side : c_req, c_wen, c_addr, c_wdata -> bridge;
//                c_addr_ok, c_data_ok, c_rdata, c_wlast <- bridge
//   AXI side   : AR/R/AW/W/B channel signals, AXI4 naming
//   optional   : c_uncached, c_size (only with DCACHE_BRIDGE_UNCACHED_EN)
// Modports: master = bridge view, slave = cache + crossbar view.
interface dcache_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  c_req;
    logic                  c_wen;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_wdata;
    logic                  c_addr_ok;
    logic                  c_data_ok;
    logic [31:0]           c_rdata;
    logic                  c_wlast;
`ifdef DCACHE_BRIDGE_UNCACHED_EN
    logic                  c_uncached;
    logic [1:0]            c_size;
`endif

    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [3:0]            rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [3:0]            awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  c_req, c_wen, c_addr, c_wdata,
`ifdef DCACHE_BRIDGE_UNCACHED_EN
        input  c_uncached, c_size,
`endif
        output c_addr_ok, c_data_ok, c_rdata, c_wlast,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output c_req, c_wen, c_addr, c_wdata,
`ifdef DCACHE_BRIDGE_UNCACHED_EN
        output c_uncached, c_size,
`endif
        input  c_addr_ok, c_data_ok, c_rdata, c_wlast,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: turns data-cache line refills / dirty writebacks into
// AXI4 INCR bursts (refill = LINE_WORD-beat read, writeback = LINE_WORD-beat
// write + B). One transaction in flight; per-beat cache acks are pulses.
// Ports: clk, rst (sync, active-high), bus (dcache_axi_bridge_if.master).
// Optional: `define DCACHE_BRIDGE_UNCACHED_EN adds single-beat uncached
// accesses sized by c_size with byte strobes from c_addr[1:0].
module dcache_axi_bridge #(
    parameter int         LINE_WORD  = 8,
    parameter logic [3:0] AXI_ID     = 4'b0001,
    parameter int         ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    dcache_axi_bridge_if.master bus
);

    localparam int            CW  = $clog2(LINE_WORD) + 1;
    localparam int            OFF = $clog2(LINE_WORD) + 2;
    localparam logic [CW-1:0] NW  = CW'(LINE_WORD);
    localparam logic [7:0]    LEN = 8'(LINE_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        W,
        B
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d;

    logic                  start;
    logic                  pull;
    logic                  last_word;
    logic                  w_fire;
    logic [CW-1:0]         nwords;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [3:0]            strb;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign line_addr = {bus.c_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

`ifdef DCACHE_BRIDGE_UNCACHED_EN
    logic       uc_q;
    logic [1:0] sz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            uc_q <= 1'b0;
            sz_q <= 2'b00;
        end else if (start) begin
            uc_q <= bus.c_uncached;
            sz_q <= bus.c_size;
        end
    end

    // uncached accesses keep their byte address; strobes follow it
    assign req_addr = bus.c_uncached ? bus.c_addr : line_addr;
    assign nwords   = uc_q ? CW'(1) : NW;
    assign len      = uc_q ? 8'd0 : LEN;
    assign size     = uc_q ? {1'b0, sz_q} : 3'b010;

    always_comb begin
        strb = 4'hF;
        if (uc_q) begin
            case (sz_q)
                2'd0:    strb = 4'b0001 << addr_q[1:0];
                2'd1:    strb = 4'b0011 << addr_q[1:0];
                default: strb = 4'hF;
            endcase
        end
    end
`else
    logic unused_lo;

    assign unused_lo = &{1'b0, bus.c_addr[OFF-1:0]};
    assign req_addr  = line_addr;
    assign nwords    = NW;
    assign len       = LEN;
    assign size      = 3'b010;
    assign strb      = 4'hF;
`endif

    logic unused_ok;

    assign unused_ok = &{1'b0, bus.rid, bus.rresp, bus.bresp};

    assign start     = (state_q == IDLE) && bus.c_req;
    assign w_fire    = wvalid_q && bus.wready;
    // holding register can take a word when empty or draining this cycle
    assign pull      = (state_q == W) && (!wvalid_q || bus.wready)
                       && (cnt_q < nwords);
    assign last_word = (cnt_q == nwords - CW'(1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.c_req) state_d = bus.c_wen ? AW : AR;
            AR:   if (bus.arready) state_d = R;
            R:    if (bus.rvalid && bus.rlast) state_d = IDLE;
            AW:   if (bus.awready) state_d = W;
            W:    if (w_fire && wlast_q) state_d = B;
            B:    if (bus.bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        wlast_d  = wlast_q;
        if (start) begin
            addr_d = req_addr;
        end
        unique case (state_q)
            IDLE: cnt_d = '0;
            R: begin
                // the burst ends on rlast only, whatever the count says
                if (bus.rvalid) begin
                    cnt_d = bus.rlast ? '0 : cnt_q + CW'(1);
                end
            end
            W: begin
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                end
                if (pull) begin
                    cnt_d    = cnt_q + CW'(1);
                    wdata_d  = bus.c_wdata;
                    wvalid_d = 1'b1;
                    wlast_d  = last_word;
                end
            end
            B: if (bus.bvalid) cnt_d = '0;
            default: cnt_d = cnt_q;
        endcase
    end

    // outputs
    always_comb begin
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b0;
        bus.awvalid   = 1'b0;
        bus.bready    = 1'b0;
        bus.c_addr_ok = 1'b0;
        bus.c_data_ok = 1'b0;
        bus.c_wlast   = 1'b0;
        bus.c_rdata   = '0;
        unique case (state_q)
            AR: begin
                bus.arvalid   = 1'b1;
                bus.c_addr_ok = bus.arready;
            end
            R: begin
                bus.rready    = 1'b1;
                bus.c_data_ok = bus.rvalid;
                bus.c_rdata   = bus.rvalid ? bus.rdata : '0;
                bus.c_wlast   = bus.rvalid && bus.rlast;
            end
            AW: begin
                bus.awvalid   = 1'b1;
                bus.c_addr_ok = bus.awready;
            end
            W: begin
                bus.c_data_ok = pull;
                bus.c_wlast   = pull && last_word;
            end
            B: bus.bready = 1'b1;
            default: bus.bready = 1'b0;
        endcase
    end

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len;
    assign bus.arsize  = size;
    assign bus.arburst = 2'b01;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = len;
    assign bus.awsize  = size;
    assign bus.awburst = 2'b01;

    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = strb;
    assign bus.wlast   = wlast_q;
    assign bus.wvalid  = wvalid_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge: directed per-cycle vector table for refill and
// writeback, plus hand sequences for backpressure, reset and uncached.
module tb_dcache_axi_bridge;

    logic clk;
    logic rst;

    dcache_axi_bridge_if #(.ADDR_WIDTH(32)) bus ();

    dcache_axi_bridge #(
        .LINE_WORD (8),
        .AXI_ID    (4'b0001),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req, wen;
        logic [31:0] addr, wd;
        logic        arr, rv, rl;
        logic [31:0] rd;
        logic        awr, wr, bv;
        logic        e_arv, e_rr, e_awv, e_wv, e_wl;
        logic        e_br, e_aok, e_dok, e_cwl;
        logic [31:0] e_data, e_addr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_chk = 0;
    int   errs  = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s (vec %0d): got %h want %h", nm, n_vec, act, exp);
        end
    endtask

    task automatic v(
        input logic req, wen, input logic [31:0] addr, wd,
        input logic arr, rv, rl, input logic [31:0] rd,
        input logic awr, wr, bv,
        input logic e_arv, e_rr, e_awv, e_wv, e_wl,
        input logic e_br, e_aok, e_dok, e_cwl,
        input logic [31:0] e_data, e_addr
    );
        vec_t t;
        t.req = req; t.wen = wen; t.addr = addr; t.wd = wd;
        t.arr = arr; t.rv = rv; t.rl = rl; t.rd = rd;
        t.awr = awr; t.wr = wr; t.bv = bv;
        t.e_arv = e_arv; t.e_rr = e_rr; t.e_awv = e_awv;
        t.e_wv = e_wv; t.e_wl = e_wl; t.e_br = e_br;
        t.e_aok = e_aok; t.e_dok = e_dok; t.e_cwl = e_cwl;
        t.e_data = e_data; t.e_addr = e_addr;
        tbl.push_back(t);
    endtask

    task automatic idle_inputs();
        bus.c_req = 0; bus.c_wen = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rdata = 0;
        bus.rid = 4'b0001; bus.rresp = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
`ifdef DCACHE_BRIDGE_UNCACHED_EN
        bus.c_uncached = 0; bus.c_size = 0;
`endif
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_arvalid"}, bus.arvalid, 0);
        chk({tag, "_awvalid"}, bus.awvalid, 0);
        chk({tag, "_wvalid"}, bus.wvalid, 0);
        chk({tag, "_rready"}, bus.rready, 0);
        chk({tag, "_bready"}, bus.bready, 0);
        chk({tag, "_addr_ok"}, bus.c_addr_ok, 0);
        chk({tag, "_data_ok"}, bus.c_data_ok, 0);
        chk({tag, "_c_wlast"}, bus.c_wlast, 0);
    endtask

    initial begin
        vec_t t;
        int   pulled, got;
        logic done, stall;
        logic [31:0] prev_d;
        logic prev_l;

        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk_quiet("rst");
        chk("rst_wlast", bus.wlast, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_c_rdata", bus.c_rdata, 0);
        rst = 0;

        n_vec++;
        chk("arid", bus.arid, 4'b0001);
        chk("arlen", bus.arlen, 7);
        chk("arsize", bus.arsize, 3'b010);
        chk("arburst", bus.arburst, 2'b01);
        chk("awid", bus.awid, 4'b0001);
        chk("awlen", bus.awlen, 7);
        chk("awsize", bus.awsize, 3'b010);
        chk("awburst", bus.awburst, 2'b01);
        chk("wstrb", bus.wstrb, 4'hF);

        // refill, arready after two waiting cycles
        v(1,0,32'h1FC0_1234,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0);
        repeat (2)
            v(0,0,32'hDEAD_BEEF,0, 0,0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,0, 0,32'h1FC0_1220);
        v(0,0,0,0, 1,0,0,0, 0,0,0, 1,0,0,0,0,0,1,0,0, 0,32'h1FC0_1220);
        for (int i = 0; i < 8; i++)
            v(0,0,0,0, 0,1,i==7,32'hA0+i, 0,0,0, 0,1,0,0,0,0,0,1,i==7, 32'hA0+i,0);
        v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0);

        // refill with a 3-cycle R gap, c_req/c_wen held high throughout
        v(1,0,32'h0000_1008,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0);
        v(1,1,32'hFFFF_FFFF,0, 1,0,0,0, 0,0,0, 1,0,0,0,0,0,1,0,0, 0,32'h0000_1000);
        for (int i = 0; i < 8; i++) begin
            if (i == 4)
                repeat (3)
                    v(1,1,32'hFFFF_FFFF,0, 0,0,0,32'h5555_5555, 0,0,0, 0,1,0,0,0,0,0,0,0, 0,0);
            v(1,1,32'hFFFF_FFFF,0, 0,1,i==7,32'hC0+i, 0,0,0, 0,1,0,0,0,0,0,1,i==7, 32'hC0+i,0);
        end
        // mandatory IDLE cycle; the held request starts a writeback here
        v(1,1,32'h0000_8047,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0);

        // full-rate writeback
        v(0,0,0,0, 0,0,0,0, 1,0,0, 0,0,1,0,0,0,1,0,0, 0,32'h0000_8040);
        v(0,0,0,32'h10, 0,0,0,0, 0,1,0, 0,0,0,0,0,0,0,1,0, 0,0);
        for (int k = 1; k < 8; k++)
            v(0,0,0,32'h10+k, 0,0,0,0, 0,1,0, 0,0,0,1,0,0,0,1,k==7, 32'h10+k-1,0);
        v(0,0,0,0, 0,0,0,0, 0,1,0, 0,0,0,1,1,0,0,0,0, 32'h17,0);
        v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0,0,0, 0,0);
        v(0,0,0,0, 0,0,0,0, 0,0,1, 0,0,0,0,0,1,0,0,0, 0,0);
        v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0, 0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            @(negedge clk);
            bus.c_req = t.req; bus.c_wen = t.wen;
            bus.c_addr = t.addr; bus.c_wdata = t.wd;
            bus.arready = t.arr; bus.rvalid = t.rv;
            bus.rlast = t.rl; bus.rdata = t.rd;
            bus.awready = t.awr; bus.wready = t.wr; bus.bvalid = t.bv;
            #1;
            n_vec++;
            chk("arvalid", bus.arvalid, t.e_arv);
            chk("rready", bus.rready, t.e_rr);
            chk("awvalid", bus.awvalid, t.e_awv);
            chk("wvalid", bus.wvalid, t.e_wv);
            chk("wlast", bus.wlast, t.e_wl);
            chk("bready", bus.bready, t.e_br);
            chk("c_addr_ok", bus.c_addr_ok, t.e_aok);
            chk("c_data_ok", bus.c_data_ok, t.e_dok);
            chk("c_wlast", bus.c_wlast, t.e_cwl);
            if (t.e_arv) chk("araddr", bus.araddr, t.e_addr);
            if (t.e_awv) chk("awaddr", bus.awaddr, t.e_addr);
            if (t.e_rr && t.e_dok) chk("c_rdata", bus.c_rdata, t.e_data);
            if (t.e_wv) chk("wdata", bus.wdata, t.e_data);
        end

        // writeback under wready pattern 1,0,0,1,0,0,...
        @(negedge clk);
        idle_inputs();
        bus.c_req = 1; bus.c_wen = 1; bus.c_addr = 32'h0000_2000;
        @(negedge clk);
        bus.c_req = 0; bus.awready = 1;
        #1;
        n_vec++;
        chk("bp_addr_ok", bus.c_addr_ok, 1);
        chk("bp_awaddr", bus.awaddr, 32'h0000_2000);
        pulled = 0; got = 0; done = 0; stall = 0;
        prev_d = 0; prev_l = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            bus.awready = 0;
            bus.wready = (cyc % 3 == 0);
            bus.c_wdata = 32'h20 + pulled;
            #1;
            n_vec++;
            if (stall) begin
                chk("bp_hold_wvalid", bus.wvalid, 1);
                chk("bp_hold_wdata", bus.wdata, prev_d);
                chk("bp_hold_wlast", bus.wlast, prev_l);
            end
            if (bus.wvalid && !bus.wready)
                chk("bp_stall_data_ok", bus.c_data_ok, 0);
            if (bus.c_data_ok) pulled++;
            if (bus.wvalid && bus.wready) begin
                chk("bp_beat", bus.wdata, 32'h20 + got);
                chk("bp_wlast", bus.wlast, got == 7);
                got++;
                if (bus.wlast) done = 1;
            end
            stall  = bus.wvalid && !bus.wready;
            prev_d = bus.wdata;
            prev_l = bus.wlast;
        end
        n_vec++;
        chk("bp_done", done, 1);
        chk("bp_beats", got, 8);
        chk("bp_pulled", pulled, 8);
        @(negedge clk);
        bus.wready = 0; bus.bvalid = 1;
        #1;
        chk("bp_bready", bus.bready, 1);
        chk("bp_b_wvalid", bus.wvalid, 0);
        @(negedge clk);
        bus.bvalid = 0;
        #1;
        n_vec++;
        chk_quiet("bp_idle");

        // reset after the fourth W beat has been accepted
        @(negedge clk);
        bus.c_req = 1; bus.c_wen = 1; bus.c_addr = 32'h0000_3000;
        bus.wready = 1;
        @(negedge clk);
        bus.c_req = 0; bus.awready = 1;
        @(negedge clk);
        bus.awready = 0; bus.c_wdata = 32'h30;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.c_wdata = 32'h30 + k;
        end
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_wvalid_pre", bus.wvalid, 1);
        @(negedge clk);
        #1;
        n_vec++;
        chk_quiet("mid_rst");
        chk("mid_rst_wlast", bus.wlast, 0);
        rst = 0;
        idle_inputs();

        // a normal refill after the mid-burst reset
        @(negedge clk);
        bus.c_req = 1; bus.c_addr = 32'h0000_4444;
        @(negedge clk);
        bus.c_req = 0; bus.arready = 1;
        #1;
        n_vec++;
        chk("post_arvalid", bus.arvalid, 1);
        chk("post_araddr", bus.araddr, 32'h0000_4440);
        chk("post_addr_ok", bus.c_addr_ok, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.arready = 0;
            bus.rvalid = 1; bus.rdata = 32'hB0 + i; bus.rlast = (i == 7);
            #1;
            n_vec++;
            chk("post_data_ok", bus.c_data_ok, 1);
            chk("post_rdata", bus.c_rdata, 32'hB0 + i);
            chk("post_c_wlast", bus.c_wlast, i == 7);
        end
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0;
        #1;
        n_vec++;
        chk_quiet("post_idle");

`ifdef DCACHE_BRIDGE_UNCACHED_EN
        // uncached halfword store at byte offset 2
        @(negedge clk);
        bus.c_req = 1; bus.c_wen = 1; bus.c_uncached = 1; bus.c_size = 1;
        bus.c_addr = 32'hBFAF_0002;
        @(negedge clk);
        bus.c_req = 0; bus.c_uncached = 0; bus.c_size = 0;
        bus.awready = 1;
        #1;
        n_vec++;
        chk("uc_awvalid", bus.awvalid, 1);
        chk("uc_awaddr", bus.awaddr, 32'hBFAF_0002);
        chk("uc_awlen", bus.awlen, 0);
        chk("uc_awsize", bus.awsize, 3'b001);
        chk("uc_addr_ok", bus.c_addr_ok, 1);
        @(negedge clk);
        bus.awready = 0; bus.wready = 1; bus.c_wdata = 32'hCAFE_F00D;
        #1;
        n_vec++;
        chk("uc_data_ok", bus.c_data_ok, 1);
        chk("uc_c_wlast", bus.c_wlast, 1);
        @(negedge clk);
        #1;
        n_vec++;
        chk("uc_wvalid", bus.wvalid, 1);
        chk("uc_wlast", bus.wlast, 1);
        chk("uc_wstrb", bus.wstrb, 4'b1100);
        chk("uc_wdata", bus.wdata, 32'hCAFE_F00D);
        chk("uc_no_pull", bus.c_data_ok, 0);
        @(negedge clk);
        bus.wready = 0; bus.bvalid = 1;
        #1;
        chk("uc_bready", bus.bready, 1);
        @(negedge clk);
        bus.bvalid = 0;
        #1;
        n_vec++;
        chk_quiet("uc_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end

endmodule
